key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_event_pkg.sv | 23 ++
 rtl/key_event_key_fsm.sv | 124 ++++++++++++
 rtl/key_event.sv | 60 ++++++
 tb/tb_key_event.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the key_event block: per-key state encoding,
// default timing constants and a counter-width helper.
package key_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS_CHK = 3'd1,
    ST_PRESSED   = 3'd2,
    ST_HELD      = 3'd3,
    ST_REL_CHK   = 3'd4
  } key_state_t;

  localparam int DEF_SAMPLE_DIV = 500000;
  localparam int DEF_STABLE_CNT = 3;
  localparam int DEF_LONG_CNT   = 100;
  localparam int DEF_REPEAT_CNT = 10;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/key_event_key_fsm.sv
// One push-button: debounce / long-press / auto-repeat state machine with
// saturating counters and one-clk registered event pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | key released and accepted as released
//   PRESS_CHK | pressed samples seen, waiting for STABLE_CNT in a row
//   PRESSED   | press accepted, counting ticks towards a long press
//   HELD      | long press reached, emitting auto-repeat pulses
//   REL_CHK   | released samples seen, waiting for STABLE_CNT in a row
module key_fsm
  import key_event_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pressed,
  output logic press,
  output logic long_press,
  output logic rpt,
  output logic level
);

  localparam int STB_W = cnt_width(STABLE_CNT);
  localparam int HLD_W = cnt_width(LONG_CNT);
  localparam int RPT_W = cnt_width(REPEAT_CNT);

  localparam logic [STB_W-1:0] STABLE_LAST = STB_W'(STABLE_CNT - 1);
  localparam logic [HLD_W-1:0] HOLD_LAST   = HLD_W'(LONG_CNT - 1);
  localparam logic [RPT_W-1:0] REPEAT_LAST = RPT_W'(REPEAT_CNT - 1);

  key_state_t       state;
  logic [STB_W-1:0] stable_cnt;
  logic [HLD_W-1:0] hold_cnt;
  logic [RPT_W-1:0] repeat_cnt;

  assign level = (state == ST_PRESSED) || (state == ST_HELD) || (state == ST_REL_CHK);

  // Counters compare against LAST before incrementing, so they stop at the
  // terminal value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      stable_cnt <= '0;
      hold_cnt   <= '0;
      repeat_cnt <= '0;
      press      <= 1'b0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
    end else begin
      press      <= 1'b0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (pressed) begin
              if (STABLE_CNT == 1) begin
                state    <= ST_PRESSED;
                press    <= 1'b1;
                hold_cnt <= '0;
              end else begin
                state      <= ST_PRESS_CHK;
                stable_cnt <= STB_W'(1);
              end
            end
          end
          ST_PRESS_CHK: begin
            if (!pressed) begin
              state <= ST_IDLE;
            end else if (stable_cnt >= STABLE_LAST) begin
              state    <= ST_PRESSED;
              press    <= 1'b1;
              hold_cnt <= '0;
            end else begin
              stable_cnt <= stable_cnt + 1'b1;
            end
          end
          ST_PRESSED: begin
            if (!pressed) begin
              state      <= (STABLE_CNT == 1) ? ST_IDLE : ST_REL_CHK;
              stable_cnt <= STB_W'(1);
            end else if (hold_cnt >= HOLD_LAST) begin
              state      <= ST_HELD;
              long_press <= 1'b1;
              rpt        <= 1'b1;
              repeat_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_HELD: begin
            if (!pressed) begin
              state      <= (STABLE_CNT == 1) ? ST_IDLE : ST_REL_CHK;
              stable_cnt <= STB_W'(1);
            end else if (repeat_cnt >= REPEAT_LAST) begin
              rpt        <= 1'b1;
              repeat_cnt <= '0;
            end else begin
              repeat_cnt <= repeat_cnt + 1'b1;
            end
          end
          ST_REL_CHK: begin
            // A pressed sample here is release bounce, not a fresh press.
            if (pressed) begin
              state    <= ST_PRESSED;
              hold_cnt <= '0;
            end else if (stable_cnt >= STABLE_LAST) begin
              state <= ST_IDLE;
            end else begin
              stable_cnt <= stable_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/key_event.sv
// Three-key front end: input synchronizers, shared sample-tick divider and
// one key_fsm per button.
module key_event
  import key_event_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_sw,
  output logic [2:0] o_press,
  output logic [2:0] o_long,
  output logic [2:0] o_rpt,
  output logic [2:0] o_level
);

  localparam int                DIV_W    = cnt_width(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [2:0]       sw_meta;
  logic [2:0]       sw_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  // Synchronizers reset to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= 3'b111;
      sw_sync <= 3'b111;
      div_cnt <= '0;
    end else begin
      sw_meta <= i_sw;
      sw_sync <= sw_meta;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_fsm #(
      .STABLE_CNT (STABLE_CNT),
      .LONG_CNT   (LONG_CNT),
      .REPEAT_CNT (REPEAT_CNT)
    ) u_key_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .pressed    (~sw_sync[k]),
      .press      (o_press[k]),
      .long_press (o_long[k]),
      .rpt        (o_rpt[k]),
      .level      (o_level[k])
    );
  end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with a fast sample tick (4 clk per tick).
module tb_key_event;

  logic       clk;
  logic       rst_n;
  logic [2:0] i_sw;
  logic [2:0] o_press;
  logic [2:0] o_long;
  logic [2:0] o_rpt;
  logic [2:0] o_level;

  key_event #(
    .SAMPLE_DIV (4),
    .STABLE_CNT (3),
    .LONG_CNT   (8),
    .REPEAT_CNT (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sw    (i_sw),
    .o_press (o_press),
    .o_long  (o_long),
    .o_rpt   (o_rpt),
    .o_level (o_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Pulse monitor, sampled on the falling edge.
  logic clr = 1'b0;
  int press_n[3], long_n[3], rpt_n[3];
  int press_cyc[3], long_cyc[3], rpt_first[3], rpt_last[3];
  int level_seen[3];
  int all_seen;

  always @(negedge clk) begin
    if (clr) begin
      for (int b = 0; b < 3; b++) begin
        press_n[b] = 0; long_n[b] = 0; rpt_n[b] = 0;
        press_cyc[b] = 0; long_cyc[b] = 0; rpt_first[b] = 0; rpt_last[b] = 0;
        level_seen[b] = 0;
      end
      all_seen = 0;
    end else if (rst_n) begin
      for (int b = 0; b < 3; b++) begin
        if (o_press[b]) begin press_n[b]++; press_cyc[b] = cyc; end
        if (o_long[b])  begin long_n[b]++;  long_cyc[b]  = cyc; end
        if (o_rpt[b]) begin
          if (rpt_n[b] == 0) rpt_first[b] = cyc;
          rpt_n[b]++;
          rpt_last[b] = cyc;
        end
        if (o_level[b]) level_seen[b] = 1;
      end
      if (o_press === 3'b111) all_seen = 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  int rel;

  initial begin
    rst_n = 1'b0;
    i_sw  = 3'b111;
    step(3);
    check("reset_press", int'(o_press), 0);
    check("reset_long",  int'(o_long),  0);
    check("reset_rpt",   int'(o_rpt),   0);
    check("reset_level", int'(o_level), 0);
    rst_n = 1'b1;
    step(10);

    // Clean press on key 0: 40 clk low gives 10 pressed ticks, short of a long press.
    clear_mon();
    i_sw[0] = 1'b0;
    step(30);
    check("clean_level_on", int'(o_level[0]), 1);
    step(10);
    i_sw[0] = 1'b1;
    step(6);
    check("clean_level_relchk", int'(o_level[0]), 1);
    step(54);
    check("clean_press_n", press_n[0], 1);
    check("clean_long_n",  long_n[0],  0);
    check("clean_rpt_n",   rpt_n[0],   0);
    check("clean_level_off", int'(o_level[0]), 0);
    check("clean_other_keys", press_n[1] + press_n[2], 0);

    // Bounce on key 1: samples alternate every tick, never accepted.
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      i_sw[1] = 1'b0;
      step(4);
      i_sw[1] = 1'b1;
      step(4);
    end
    step(40);
    check("bounce_press_n", press_n[1], 0);
    check("bounce_level",   level_seen[1], 0);

    // Long hold on key 2: 20 pressed ticks -> press T3, long+rpt T11, rpt T13..T19.
    clear_mon();
    i_sw[2] = 1'b0;
    step(80);
    i_sw[2] = 1'b1;
    step(40);
    check("hold_press_n", press_n[2], 1);
    check("hold_long_n",  long_n[2],  1);
    check("hold_long_delay", long_cyc[2] - press_cyc[2], 32);
    check("hold_rpt_with_long", rpt_first[2] - long_cyc[2], 0);
    check("hold_rpt_n", rpt_n[2], 5);
    check("hold_rpt_span", rpt_last[2] - long_cyc[2], 32);
    check("hold_key0_quiet", press_n[0], 0);

    // One-tick release glitch at T7: no new press, long press moves to T16.
    clear_mon();
    i_sw[0] = 1'b0;
    step(24);
    i_sw[0] = 1'b1;
    step(4);
    i_sw[0] = 1'b0;
    step(52);
    i_sw[0] = 1'b1;
    step(40);
    check("glitch_press_n", press_n[0], 1);
    check("glitch_long_n",  long_n[0],  1);
    check("glitch_long_delay", long_cyc[0] - press_cyc[0], 52);

    // All three keys in the same clk.
    clear_mon();
    i_sw = 3'b000;
    step(30);
    check("simul_all_seen", all_seen, 1);
    check("simul_press_0", press_n[0], 1);
    check("simul_press_1", press_n[1], 1);
    check("simul_press_2", press_n[2], 1);
    i_sw = 3'b111;
    step(40);
    check("simul_level_off", int'(o_level), 0);

    // Reset while key 2 is HELD; press must be re-qualified from scratch.
    clear_mon();
    i_sw[2] = 1'b0;
    step(60);
    check("rst_pre_long", long_n[2], 1);
    rst_n = 1'b0;
    clr   = 1'b1;
    #1;
    check("rst_async_level", int'(o_level), 0);
    check("rst_async_pulses", int'(o_press | o_long | o_rpt), 0);
    step(3);
    check("rst_hold_level", int'(o_level), 0);
    clr   = 1'b0;
    rst_n = 1'b1;
    rel   = cyc;
    step(30);
    check("rst_repress_n", press_n[2], 1);
    check("rst_repress_delay", press_cyc[2] - rel, 12);
    check("rst_no_long", long_n[2], 0);
    i_sw = 3'b111;
    step(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
